// File: rtl/text_reader.sv
// Streams the 15x20 text buffer out as characters, skipping empty (zero) cells
// and closing every row with an LF. Handshaked output, abortable at any time.
module text_reader (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  output logic       read_enable,
  output logic [8:0] read_out_addr,
  input  logic [7:0] ram_data,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {StIdle, StAddr, StData, StEmit, StNl, StDone} state_e;

  localparam logic [3:0] LastRow = 4'd14;
  localparam logic [4:0] LastCol = 5'd19;
  localparam logic [7:0] LineFeed = 8'h0A;

  state_e     state_q, state_d;
  logic [3:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic [7:0] data_q, data_d;
  logic       cell_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= 4'd0;
      col_q   <= 5'd0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    data_d   = data_q;
    cell_adv = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          row_d   = 4'd0;
          col_d   = 5'd0;
          state_d = StAddr;
        end
      end
      StAddr: state_d = StData;
      StData: begin
        if (ram_data == 8'h00) begin
          cell_adv = 1'b1;
        end else begin
          data_d  = ram_data;
          state_d = StEmit;
        end
      end
      StEmit: cell_adv = out_ready;
      StNl: begin
        if (out_ready) begin
          if (row_q < LastRow) begin
            row_d   = row_q + 4'd1;
            col_d   = 5'd0;
            state_d = StAddr;
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (cell_adv) begin
      if (col_q < LastCol) begin
        col_d   = col_q + 5'd1;
        state_d = StAddr;
      end else begin
        state_d = StNl;
      end
    end

    // Abort overrides everything, including a start seen in idle.
    if (abort) state_d = StIdle;
  end

  // Abort gates valid/done combinationally so no transfer completes on the abort cycle.
  always_comb begin
    busy          = (state_q != StIdle);
    read_enable   = busy;
    read_out_addr = busy ? {row_q, col_q} : 9'd0;
    out_valid     = ((state_q == StEmit) || (state_q == StNl)) && !abort;
    out_data      = (state_q == StNl) ? LineFeed : data_q;
    done          = (state_q == StDone) && !abort;
  end

endmodule
